// File: rtl/falco_dmem_router_pkg.sv
// Shared types and defaults for the Falco data-memory router.
// FALCO_DMEM_ROUTER_PERF_EN (top file) enables per-target performance counters.
package falco_dmem_router_pkg;

    localparam int IDX_W   = 3;
    localparam int MAX_TGT = 8;

    // Nibble i holds the segment id of target i: tgt0=0x0, tgt1=0x1, tgt2=0x8, tgt3=0xF.
    localparam logic [31:0] DEFAULT_SEG_MAP = 32'h0000_F810;

    typedef logic [3:0] seg_id_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             err;
    } dmem_tag_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } st_state_e;

endpackage

// File: rtl/falco_dmem_router_seg_decode.sv
// Combinational address -> target decode: one-hot select, binary index, unmapped flag.
module falco_dmem_router_seg_decode
    import falco_dmem_router_pkg::*;
#(
    parameter int          XLEN_WIDTH = 32,
    parameter int          NUM_TGT    = 4,
    parameter int          SEG_MSB    = 31,
    parameter int          SEG_LSB    = 28,
    parameter logic [31:0] SEG_MAP    = DEFAULT_SEG_MAP,
    parameter int          DTCM_ALIAS = 1
) (
    input  logic [XLEN_WIDTH-1:0] addr,
    output logic [NUM_TGT-1:0]    sel,
    output logic [IDX_W-1:0]      idx,
    output logic                  unmapped
);

    seg_id_t seg_id;
    logic    unused_addr_bits;

    assign unused_addr_bits = ^addr;

    always_comb begin
        seg_id = addr[SEG_MSB:SEG_LSB];
        if ((DTCM_ALIAS != 0) && (addr[19:16] == 4'h1)) begin
            seg_id = 4'h1;
        end
        sel      = '0;
        idx      = '0;
        unmapped = 1'b1;
        // Scan downwards so the lowest matching target is the last one written.
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if (SEG_MAP[4*i +: 4] == seg_id) begin
                sel      = '0;
                sel[i]   = 1'b1;
                idx      = IDX_W'(i);
                unmapped = 1'b0;
            end
        end
    end

endmodule

// File: rtl/falco_dmem_router.sv
// LSU-to-slave data-memory router: load fan-out with tag pipeline, store FSM with timeout.
// Optional per-target counters when FALCO_DMEM_ROUTER_PERF_EN is defined.
module falco_dmem_router
    import falco_dmem_router_pkg::*;
#(
    parameter int          XLEN_WIDTH    = 32,
    parameter int          NUM_TGT       = 4,
    parameter int          SEG_MSB       = 31,
    parameter int          SEG_LSB       = 28,
    parameter logic [31:0] SEG_MAP       = DEFAULT_SEG_MAP,
    parameter int          DTCM_ALIAS    = 1,
    parameter int          LD_PIPE_DEPTH = 2,
    parameter int          ST_TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall_i,
    input  logic                          core_ld_req,
    input  logic                          core_ld_kill,
    input  logic [XLEN_WIDTH-1:0]         core_ld_addr,
    output logic                          core_ld_hit,
    output logic                          core_ld_miss,
    output logic                          core_ld_done,
    output logic [XLEN_WIDTH-1:0]         core_ld_data,
    output logic                          core_ld_err,
    input  logic                          core_st_req,
    input  logic [XLEN_WIDTH-1:0]         core_st_addr,
    input  logic [XLEN_WIDTH/8-1:0]       core_st_mask,
    input  logic [XLEN_WIDTH-1:0]         core_st_data,
    output logic                          core_st_done,
    output logic                          core_st_err,
    output logic                          core_st_busy,
    output logic [NUM_TGT-1:0]            tgt_ld_req,
    output logic [NUM_TGT-1:0]            tgt_ld_kill,
    output logic [XLEN_WIDTH-1:0]         tgt_ld_addr,
    input  logic [NUM_TGT-1:0]            tgt_ld_hit,
    input  logic [NUM_TGT-1:0]            tgt_ld_miss,
    input  logic [NUM_TGT-1:0]            tgt_ld_done,
    input  logic [NUM_TGT*XLEN_WIDTH-1:0] tgt_ld_data,
    output logic [NUM_TGT-1:0]            tgt_st_req,
    output logic [XLEN_WIDTH-1:0]         tgt_st_addr,
    output logic [XLEN_WIDTH-1:0]         tgt_st_data,
    output logic [XLEN_WIDTH/8-1:0]       tgt_st_mask,
    input  logic [NUM_TGT-1:0]            tgt_st_done
`ifdef FALCO_DMEM_ROUTER_PERF_EN
    ,
    output logic [NUM_TGT*32-1:0]         perf_ld_cnt,
    output logic [NUM_TGT*32-1:0]         perf_st_cnt
`endif
);

    localparam int CNT_W = (ST_TIMEOUT > 0) ? $clog2(ST_TIMEOUT + 1) : 1;

    logic [NUM_TGT-1:0] ld_sel, st_sel;
    logic [IDX_W-1:0]   ld_idx, st_idx;
    logic               ld_unmapped, st_unmapped;

    falco_dmem_router_seg_decode #(
        .XLEN_WIDTH(XLEN_WIDTH), .NUM_TGT(NUM_TGT), .SEG_MSB(SEG_MSB),
        .SEG_LSB(SEG_LSB), .SEG_MAP(SEG_MAP), .DTCM_ALIAS(DTCM_ALIAS)
    ) u_ld_dec (
        .addr(core_ld_addr), .sel(ld_sel), .idx(ld_idx), .unmapped(ld_unmapped)
    );

    falco_dmem_router_seg_decode #(
        .XLEN_WIDTH(XLEN_WIDTH), .NUM_TGT(NUM_TGT), .SEG_MSB(SEG_MSB),
        .SEG_LSB(SEG_LSB), .SEG_MAP(SEG_MAP), .DTCM_ALIAS(DTCM_ALIAS)
    ) u_st_dec (
        .addr(core_st_addr), .sel(st_sel), .idx(st_idx), .unmapped(st_unmapped)
    );

    assign tgt_ld_req  = (rst && core_ld_req)  ? ld_sel : '0;
    assign tgt_ld_kill = (rst && core_ld_kill) ? ld_sel : '0;
    assign tgt_ld_addr = core_ld_addr;

    always_comb begin
        core_ld_hit  = ld_unmapped;
        core_ld_miss = 1'b0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (ld_sel[i]) begin
                core_ld_hit  = tgt_ld_hit[i];
                core_ld_miss = tgt_ld_miss[i];
            end
        end
    end

    dmem_tag_t tag_q [LD_PIPE_DEPTH];
    dmem_tag_t tag_d [LD_PIPE_DEPTH];
    dmem_tag_t wb_tag;

    always_comb begin
        for (int k = 0; k < LD_PIPE_DEPTH; k++) begin
            tag_d[k] = tag_q[k];
        end
        if (!stall_i) begin
            tag_d[0] = '{valid: core_ld_req & ~core_ld_kill, idx: ld_idx, err: ld_unmapped};
            for (int k = 1; k < LD_PIPE_DEPTH; k++) begin
                tag_d[k] = tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LD_PIPE_DEPTH; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LD_PIPE_DEPTH; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    logic                  wb_tgt_done;
    logic [XLEN_WIDTH-1:0] wb_tgt_data;

    assign wb_tag = tag_q[LD_PIPE_DEPTH-1];

    always_comb begin
        wb_tgt_done = 1'b0;
        wb_tgt_data = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (wb_tag.idx == IDX_W'(i)) begin
                wb_tgt_done = tgt_ld_done[i];
                wb_tgt_data = tgt_ld_data[i*XLEN_WIDTH +: XLEN_WIDTH];
            end
        end
    end

    assign core_ld_done = wb_tag.valid & (wb_tag.err | wb_tgt_done);
    assign core_ld_err  = wb_tag.valid & wb_tag.err;
    assign core_ld_data = (wb_tag.valid && !wb_tag.err) ? wb_tgt_data : '0;

    st_state_e          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_TGT-1:0] st_req_vec;
    logic               st_done, st_err, timeout_hit;

    assign timeout_hit = (ST_TIMEOUT != 0) && (cnt_q == CNT_W'(ST_TIMEOUT));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        st_done    = 1'b0;
        st_err     = 1'b0;
        st_req_vec = '0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (core_st_req) begin
                    if (st_unmapped) begin
                        st_done = 1'b1;
                        st_err  = 1'b1;
                    end else begin
                        st_req_vec = st_sel;
                        if (|(st_sel & tgt_st_done)) begin
                            st_done = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                            idx_d   = st_idx;
                        end
                    end
                end
            end
            ST_WAIT: begin
                // Timeout wins over a same-cycle done: the request is already withdrawn.
                if (timeout_hit) begin
                    st_done = 1'b1;
                    st_err  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    for (int i = 0; i < NUM_TGT; i++) begin
                        st_req_vec[i] = (idx_q == IDX_W'(i));
                    end
                    if (|(st_req_vec & tgt_st_done)) begin
                        st_done = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tgt_st_req   = rst ? st_req_vec : '0;
    assign core_st_done = rst & st_done;
    assign core_st_err  = rst & st_err;
    assign core_st_busy = core_st_req & ~core_st_done;
    assign tgt_st_addr  = core_st_addr;
    assign tgt_st_data  = core_st_data;
    assign tgt_st_mask  = core_st_mask;

`ifdef FALCO_DMEM_ROUTER_PERF_EN
    logic [IDX_W-1:0] perf_st_idx;
    assign perf_st_idx = (state_q == ST_IDLE) ? st_idx : idx_q;

    for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_perf
        logic [31:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;

        always_comb begin
            ld_cnt_d = ld_cnt_q + 32'(~stall_i & core_ld_req & ~core_ld_kill & ld_sel[gi]);
            st_cnt_d = st_cnt_q + 32'(core_st_done & ~core_st_err & (perf_st_idx == IDX_W'(gi)));
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ld_cnt_q <= '0;
                st_cnt_q <= '0;
            end else begin
                ld_cnt_q <= ld_cnt_d;
                st_cnt_q <= st_cnt_d;
            end
        end

        assign perf_ld_cnt[gi*32 +: 32] = ld_cnt_q;
        assign perf_st_cnt[gi*32 +: 32] = st_cnt_q;
    end
`endif

endmodule

// File: tb/tb_falco_dmem_router.sv
// Self-checking bench for falco_dmem_router: decode table, WB scoreboard, store FSM sequences.
module tb_falco_dmem_router;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        core_ld_req, core_ld_kill;
    logic [31:0] core_ld_addr;
    logic        core_ld_hit, core_ld_miss, core_ld_done, core_ld_err;
    logic [31:0] core_ld_data;
    logic        core_st_req;
    logic [31:0] core_st_addr, core_st_data;
    logic [3:0]  core_st_mask;
    logic        core_st_done, core_st_err, core_st_busy;
    logic [3:0]  tgt_ld_req, tgt_ld_kill, tgt_ld_hit, tgt_ld_miss, tgt_ld_done;
    logic [31:0] tgt_ld_addr;
    logic [127:0] tgt_ld_data;
    logic [3:0]  tgt_st_req, tgt_st_done, tgt_st_mask;
    logic [31:0] tgt_st_addr, tgt_st_data;
    logic [31:0] tdata [4];
`ifdef FALCO_DMEM_ROUTER_PERF_EN
    logic [127:0] perf_ld_cnt, perf_st_cnt;
`endif

    falco_dmem_router dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .core_ld_req(core_ld_req), .core_ld_kill(core_ld_kill), .core_ld_addr(core_ld_addr),
        .core_ld_hit(core_ld_hit), .core_ld_miss(core_ld_miss), .core_ld_done(core_ld_done),
        .core_ld_data(core_ld_data), .core_ld_err(core_ld_err),
        .core_st_req(core_st_req), .core_st_addr(core_st_addr), .core_st_mask(core_st_mask),
        .core_st_data(core_st_data), .core_st_done(core_st_done), .core_st_err(core_st_err),
        .core_st_busy(core_st_busy),
        .tgt_ld_req(tgt_ld_req), .tgt_ld_kill(tgt_ld_kill), .tgt_ld_addr(tgt_ld_addr),
        .tgt_ld_hit(tgt_ld_hit), .tgt_ld_miss(tgt_ld_miss), .tgt_ld_done(tgt_ld_done),
        .tgt_ld_data(tgt_ld_data),
        .tgt_st_req(tgt_st_req), .tgt_st_addr(tgt_st_addr), .tgt_st_data(tgt_st_data),
        .tgt_st_mask(tgt_st_mask), .tgt_st_done(tgt_st_done)
`ifdef FALCO_DMEM_ROUTER_PERF_EN
        , .perf_ld_cnt(perf_ld_cnt), .perf_st_cnt(perf_st_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) tgt_ld_data[i*32 +: 32] = tdata[i];
    end

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference address map: returns target number, or -1 when unmapped.
    function automatic int ref_tgt(input logic [31:0] a);
        if (a[19:16] == 4'h1) return 1;
        case (a[31:28])
            4'h0: return 0;
            4'h1: return 1;
            4'h8: return 2;
            4'hF: return 3;
            default: return -1;
        endcase
    endfunction

    typedef struct packed {
        logic       v;
        logic [1:0] idx;
        logic       err;
    } tb_tag_t;

    tb_tag_t sb_q[$];

    // Scoreboard: the load issued in each advancing cycle is pushed; the head is the WB expectation.
    always @(posedge clk) begin : sb_shift
        int t;
        if (!rst) begin
            sb_q.delete();
            for (int k = 0; k < DEPTH; k++) sb_q.push_back('0);
        end else if (!stall_i) begin
            t = ref_tgt(core_ld_addr);
            sb_q.push_back('{v: core_ld_req & ~core_ld_kill, idx: (t < 0) ? 2'd0 : 2'(t), err: (t < 0)});
            void'(sb_q.pop_front());
        end
    end

    always @(negedge clk) begin : wb_check
        tb_tag_t e;
        if (rst && chk_en && sb_q.size() > 0) begin
            e = sb_q[0];
            chk("wb_done", {31'd0, core_ld_done}, {31'd0, e.v & (e.err | tgt_ld_done[e.idx])});
            chk("wb_err", {31'd0, core_ld_err}, {31'd0, e.v & e.err});
            chk("wb_data", core_ld_data, (e.v && !e.err) ? tdata[e.idx] : 32'd0);
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        kill;
        logic [3:0]  exp_req;
        logic        exp_hit;
        logic        exp_miss;
    } ld_vec_t;

    ld_vec_t vecs [10];
    logic    early;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // tgt_ld_hit=0101 / tgt_ld_miss=1010 during the table: even targets hit, odd miss.
        vecs[0] = '{32'h0000_0100, 1'b0, 4'b0001, 1'b1, 1'b0};
        vecs[1] = '{32'h1000_0040, 1'b0, 4'b0010, 1'b0, 1'b1};
        vecs[2] = '{32'h8001_0000, 1'b0, 4'b0010, 1'b0, 1'b1};
        vecs[3] = '{32'h8000_0000, 1'b1, 4'b0100, 1'b1, 1'b0};
        vecs[4] = '{32'hF000_0000, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[5] = '{32'hF012_3456, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[6] = '{32'h5000_0000, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[7] = '{32'h0001_0000, 1'b1, 4'b0010, 1'b0, 1'b1};
        vecs[8] = '{32'h5001_0004, 1'b0, 4'b0010, 1'b0, 1'b1};
        vecs[9] = '{32'h2000_0000, 1'b0, 4'b0000, 1'b1, 1'b0};

        stall_i = 0; core_ld_req = 1; core_ld_kill = 1; core_ld_addr = 32'h1000_0000;
        core_st_req = 1; core_st_addr = 32'h5000_0000; core_st_data = 32'h1234_5678; core_st_mask = 4'hF;
        tgt_ld_hit = 0; tgt_ld_miss = 0; tgt_ld_done = 4'hF; tgt_st_done = 0;
        for (int i = 0; i < 4; i++) tdata[i] = 32'hA000_0000 + i;
        rst = 1;
        #1 rst = 0;
        #5;
        chk("rst_ld_req", {28'd0, tgt_ld_req}, 32'd0);
        chk("rst_ld_kill", {28'd0, tgt_ld_kill}, 32'd0);
        chk("rst_st_req", {28'd0, tgt_st_req}, 32'd0);
        chk("rst_st_done", {30'd0, core_st_done, core_st_err}, 32'd0);
        chk("rst_ld_done", {30'd0, core_ld_done, core_ld_err}, 32'd0);
        step();
        core_ld_req = 0; core_ld_kill = 0; core_st_req = 0;
        step();
        rst = 1; chk_en = 1;

        for (int i = 0; i < 10; i++) begin
            step();
            core_ld_req = 1; core_ld_addr = vecs[i].addr; core_ld_kill = vecs[i].kill;
            tgt_ld_hit = 4'b0101; tgt_ld_miss = 4'b1010; tgt_ld_done = 4'b1101;
            for (int t = 0; t < 4; t++) tdata[t] = $urandom;
            #3;
            $display("vec %0d: addr %h kill %b -> req %b kill %b hit %b miss %b",
                     i, vecs[i].addr, vecs[i].kill, tgt_ld_req, tgt_ld_kill, core_ld_hit, core_ld_miss);
            chk("tbl_ld_req", {28'd0, tgt_ld_req}, {28'd0, vecs[i].exp_req});
            chk("tbl_ld_kill", {28'd0, tgt_ld_kill}, {28'd0, vecs[i].kill ? vecs[i].exp_req : 4'b0});
            chk("tbl_hit", {31'd0, core_ld_hit}, {31'd0, vecs[i].exp_hit});
            chk("tbl_miss", {31'd0, core_ld_miss}, {31'd0, vecs[i].exp_miss});
        end
        step(); core_ld_req = 0; core_ld_kill = 0;
        repeat (3) step();

        // Load to tgt1, data returned two cycles later.
        step();
        core_ld_req = 1; core_ld_addr = 32'h1000_0040; tgt_ld_hit = 4'b0010; tgt_ld_miss = 0; tgt_ld_done = 0;
        #3 chk("ld1_hit", {31'd0, core_ld_hit}, 32'd1);
        step(); core_ld_req = 0;
        #3 chk("ld1_early", {31'd0, core_ld_done}, 32'd0);
        step(); tgt_ld_done = 4'b0010; tdata[1] = 32'hDEAD_BEEF;
        #3;
        $display("ld 10000040: done %b data %h err %b", core_ld_done, core_ld_data, core_ld_err);
        chk("ld1_done", {31'd0, core_ld_done}, 32'd1);
        chk("ld1_data", core_ld_data, 32'hDEAD_BEEF);
        chk("ld1_err", {31'd0, core_ld_err}, 32'd0);
        step(); tgt_ld_done = 0;

        // Load to tgt2 with three stall cycles behind it.
        step(); core_ld_req = 1; core_ld_addr = 32'h8000_0000; tdata[2] = 32'h2222_0001; tgt_ld_done = 4'b0100;
        early = 0;
        for (int c = 1; c <= 4; c++) begin
            step(); core_ld_req = 0; stall_i = (c <= 3);
            #3 if (core_ld_done) early = 1;
        end
        chk("stall_early", {31'd0, early}, 32'd0);
        step(); #3;
        $display("ld 80000000 stalled: done %b data %h", core_ld_done, core_ld_data);
        chk("stall_done", {31'd0, core_ld_done}, 32'd1);
        chk("stall_data", core_ld_data, 32'h2222_0001);

        // Unmapped load.
        step(); core_ld_req = 1; core_ld_addr = 32'h5000_0000; tgt_ld_hit = 0; tgt_ld_done = 0;
        #3;
        chk("um_hit", {30'd0, core_ld_hit, core_ld_miss}, 32'd2);
        chk("um_req", {28'd0, tgt_ld_req}, 32'd0);
        step(); core_ld_req = 0;
        step(); #3;
        $display("ld 50000000: done %b err %b data %h", core_ld_done, core_ld_err, core_ld_data);
        chk("um_done", {30'd0, core_ld_done, core_ld_err}, 32'd3);
        chk("um_data", core_ld_data, 32'd0);

        // Store completing in the request cycle.
        step(); core_st_req = 1; core_st_addr = 32'h0000_0000; tgt_st_done = 4'b0001;
        #3;
        $display("st 00000000: req %b done %b err %b", tgt_st_req, core_st_done, core_st_err);
        chk("st0_req", {28'd0, tgt_st_req}, 32'h1);
        chk("st0_done", {29'd0, core_st_done, core_st_err, core_st_busy}, 32'h4);

        // Unmapped store.
        step(); core_st_addr = 32'h5000_0000; tgt_st_done = 0;
        #3;
        chk("stum_req", {28'd0, tgt_st_req}, 32'd0);
        chk("stum_done", {30'd0, core_st_done, core_st_err}, 32'd3);

        // Store waits, address change ignored, then completes.
        step(); core_st_addr = 32'h8000_0000;
        #3 chk("stw_req0", {27'd0, tgt_st_req, core_st_busy}, {27'd0, 4'b0100, 1'b1});
        step(); core_st_addr = 32'h0000_0000;
        #3 chk("stw_req1", {27'd0, tgt_st_req, core_st_done}, {27'd0, 4'b0100, 1'b0});
        step(); tgt_st_done = 4'b0100;
        #3;
        $display("st 80000000 waited: done %b err %b", core_st_done, core_st_err);
        chk("stw_done", {30'd0, core_st_done, core_st_err}, 32'd2);
        step(); core_st_req = 0; tgt_st_done = 0;

        // Store timeout.
        step(); core_st_req = 1; core_st_addr = 32'hF000_0000;
        #3 chk("to_req", {28'd0, tgt_st_req}, 32'h8);
        early = 0;
        for (int c = 1; c <= 255; c++) begin
            step(); #3;
            if (core_st_done || tgt_st_req != 4'b1000) early = 1;
        end
        chk("to_hold", {31'd0, early}, 32'd0);
        step(); #3;
        $display("st F0000000 timeout: done %b err %b req %b", core_st_done, core_st_err, tgt_st_req);
        chk("to_done", {30'd0, core_st_done, core_st_err}, 32'd3);
        chk("to_drop", {28'd0, tgt_st_req}, 32'd0);
        step(); core_st_req = 0;

        // Reset pulse while waiting.
        step(); core_st_req = 1; core_st_addr = 32'hF000_0000;
        step(); #3 chk("rw_req", {28'd0, tgt_st_req}, 32'h8);
        #2 rst = 0;
        #1;
        chk("rw_drop", {26'd0, tgt_st_req, core_st_done, core_st_err}, 32'd0);
        core_st_req = 0;
        step(); step(); rst = 1;
        #3 chk("rw_idle", {27'd0, tgt_st_req, core_st_done}, 32'd0);
        step(); core_st_req = 1; core_st_addr = 32'h0000_0000; tgt_st_done = 4'b0001;
        #3;
        $display("st after reset: req %b done %b", tgt_st_req, core_st_done);
        chk("rw_new", {27'd0, tgt_st_req, core_st_done}, {27'd0, 4'b0001, 1'b1});
        step(); core_st_req = 0; tgt_st_done = 0;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
